// File: rtl/pcm_mic_if.sv
// Signal bundle between the PCM mic control FSM / microphone and the deserializer.
// The master side drives enable, frame clear and serial data; the slave side returns BCLK, events and the sample.
interface pcm_mic_if #(
    parameter int DATA_BITS = 18
);
    logic                 en_bclk;
    logic                 reset_int;
    logic                 mic_data;
    logic                 bclk;
    logic                 count18;
    logic                 count32;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;

    modport master (
        output en_bclk, reset_int, mic_data,
        input  bclk, count18, count32, sample, sample_valid
    );

    modport slave (
        input  en_bclk, reset_int, mic_data,
        output bclk, count18, count32, sample, sample_valid
    );
endinterface

// File: rtl/pcm_mic_deserializer.sv
// BCLK generator and MSB-first serial capture for a PCM microphone, returning COUNT18/COUNT32 events.
// Optional macro PCM_MIC_SYNC_EN inserts a 2-flop synchronizer on MIC_DATA (requires CLK_DIV >= 3).
module pcm_mic_deserializer #(
    parameter int CLK_DIV    = 25,
    parameter int DATA_BITS  = 18,
    parameter int FRAME_BITS = 32
) (
    input  logic     clk,
    input  logic     rst,
    pcm_mic_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]     div_reg;
    logic                 bclk_reg;
    logic [5:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] sample_reg;
    logic                 count18_reg;
    logic                 count32_reg;
    logic                 valid_reg;

    logic                 data_bit;
    logic                 tick;
    logic                 rise;
    logic                 fall;
    logic                 capture;
    logic                 frame_end;
    logic [DATA_BITS-1:0] shift_next;

`ifdef PCM_MIC_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], bus.mic_data};
        end
    end

    assign data_bit = sync_reg[1];
`else
    assign data_bit = bus.mic_data;
`endif

    // Events are only meaningful when running and not being cleared.
    always_comb begin
        tick       = bus.en_bclk && !bus.reset_int && (div_reg == DIV_W'(CLK_DIV - 1));
        rise       = tick && !bclk_reg;
        fall       = tick && bclk_reg;
        capture    = rise && (bit_cnt_reg == 6'(DATA_BITS - 1));
        frame_end  = fall && (bit_cnt_reg == 6'(FRAME_BITS));
        shift_next = {shift_reg[DATA_BITS-2:0], data_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg     <= '0;
            bclk_reg    <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            sample_reg  <= '0;
            count18_reg <= 1'b0;
            count32_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else if (bus.reset_int) begin
            div_reg     <= '0;
            bclk_reg    <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            count18_reg <= 1'b0;
            count32_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else if (!bus.en_bclk) begin
            // Forced fall: bit count and partial sample survive the pause.
            div_reg     <= '0;
            bclk_reg    <= 1'b0;
            count18_reg <= 1'b0;
            count32_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            count18_reg <= 1'b0;
            count32_reg <= 1'b0;
            valid_reg   <= 1'b0;
            if (tick) begin
                div_reg  <= '0;
                bclk_reg <= !bclk_reg;
            end else begin
                div_reg  <= div_reg + 1'b1;
            end
            if (rise) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
            if (capture) begin
                sample_reg  <= shift_next;
                count18_reg <= 1'b1;
                valid_reg   <= 1'b1;
            end
            if (frame_end) begin
                count32_reg <= 1'b1;
                bit_cnt_reg <= '0;
            end
        end
    end

    assign bus.bclk         = bclk_reg;
    assign bus.count18      = count18_reg;
    assign bus.count32      = count32_reg;
    assign bus.sample       = sample_reg;
    assign bus.sample_valid = valid_reg;
endmodule

// File: doc/pcm_mic_deserializer.md
Name: pcm_mic_deserializer

Overview:
Datapath stage paired with the PCM microphone control FSM. It consumes the FSM's EN_BCLK and RESET_INT, generates the microphone bit clock (BCLK), and shifts in the serial microphone data MSB-first. It returns the COUNT18 and COUNT32 event pulses that drive the FSM's transitions, and presents each captured 18-bit sample in parallel to the downstream audio logic.

Parameters:
CLK_DIV, 25, CLK cycles per BCLK half-period (BCLK period = 2*CLK_DIV CLK cycles); minimum 2
DATA_BITS, 18, sample bits per frame; width of SAMPLE; COUNT18 fires after this many bits
FRAME_BITS, 32, BCLK rising edges per frame; COUNT32 fires after this many bits

Ports:
CLK  input  1  system clock; all logic on the rising edge
RESET  input  1  asynchronous, active-high reset
EN_BCLK  input  1  from FSM; 1 = run BCLK divider and capture
RESET_INT  input  1  from FSM; synchronous frame clear
MIC_DATA  input  1  serial data from microphone; the mic drives it on the BCLK falling edge
BCLK  output  1  bit clock to microphone (registered)
COUNT18  output  1  to FSM; 1-cycle pulse when DATA_BITS bits have been captured
COUNT32  output  1  to FSM; 1-cycle pulse at frame end
SAMPLE  output  DATA_BITS  last captured sample, two's complement, held between frames
SAMPLE_VALID  output  1  1-cycle pulse, coincident with COUNT18

Behaviour:
- Async RESET=1: clears divider, bit_cnt, shift register and SAMPLE to 0. BCLK, COUNT18, COUNT32 and SAMPLE_VALID reset to 0.
- Priority per CLK edge: RESET > RESET_INT > EN_BCLK.
- RESET_INT=1 (synchronous): clears divider, bit_cnt and shift register. Forces BCLK=0 and all pulses to 0. SAMPLE holds its value.
- EN_BCLK=0: divider cleared, BCLK forced to 0 on the next edge, bit_cnt and shift register hold. A forced fall does not count as a bit.
- EN_BCLK=1:
  - div_cnt increments 0..CLK_DIV-1.
  - At CLK_DIV-1, div_cnt wraps to 0 and BCLK toggles.
  - The first toggle after enable is a rise, occurring CLK_DIV edges after EN_BCLK is first sampled high.
- Rise event (BCLK toggling 0->1, same edge):
  - shift register <= {shift[DATA_BITS-2:0], MIC_DATA}
  - bit_cnt <= bit_cnt+1
  - bit_cnt is 6 bits wide.
- COUNT18 / SAMPLE capture: on the rise event where bit_cnt==DATA_BITS-1 before the increment, on that same edge:
  - SAMPLE <= {shift[DATA_BITS-2:0], MIC_DATA}
  - COUNT18 <= 1
  - SAMPLE_VALID <= 1
- COUNT32: on the fall event (BCLK toggling 1->0) where bit_cnt==FRAME_BITS, COUNT32 <= 1 and bit_cnt <= 0 (wrap). The next rise starts a new frame.
- Pulses: COUNT18, COUNT32 and SAMPLE_VALID are high for exactly one CLK cycle and are otherwise 0.
- Simultaneous events: RESET_INT on the same edge as a capture suppresses the capture; SAMPLE keeps its old value and no pulse is issued.
- Bits 19..32 are shifted in but discarded; the shift register is overwritten by the next frame.

Optional Feature:
- Macro PCM_MIC_SYNC_EN.
- Defined:
  - MIC_DATA passes through a 2-flop synchronizer (reset to 0) before the shift register.
  - The captured bit is MIC_DATA as sampled 2 CLK edges before the rise event.
  - CLK_DIV must be >= 3.
- Undefined: MIC_DATA feeds the shift register directly. No extra latency.

Test Plan:
- Reset: hold RESET=1 with EN_BCLK=1 and MIC_DATA=1 -> BCLK, COUNT18, COUNT32 and SAMPLE_VALID stay 0 and SAMPLE=0. Release -> first BCLK rise 2 edges later (CLK_DIV=2).
- Full frame (CLK_DIV=2): mic model drives 18'h2A5C3 MSB-first on BCLK falls, then 14 zeros.
  - BCLK period is 4 CLK.
  - Exactly one COUNT18 pulse, with SAMPLE=18'h2A5C3 and SAMPLE_VALID high the same cycle.
  - One COUNT32 pulse 128 CLK after the first rise edge minus 2.
  - Second frame with 18'h3FFFF -> SAMPLE=18'h3FFFF.
- RESET_INT mid-frame: pulse after 10 rises -> BCLK=0 next edge, no COUNT18 in that frame, SAMPLE unchanged. COUNT18 after 18 further rises.
- EN_BCLK gap: drop EN_BCLK after 5 rises while BCLK=1 for 20 CLK -> BCLK=0, no pulses. After re-enable, COUNT18 after exactly 13 more rises, and SAMPLE equals the 18 bits driven excluding the gap.
- Async RESET mid-frame: assert between CLK edges after 12 bits -> outputs 0 immediately. After release, a full frame captures correctly.
- PCM_MIC_SYNC_EN defined (CLK_DIV=3): same frame as the second test -> identical SAMPLE=18'h2A5C3 and pulse timing.
